// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-stream in / payload-replay out bundle of the frame parser
interface uart_frame_parser_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] pl_data;
  logic       pl_flag;
  logic [7:0] cmd_out;
  logic [7:0] len_out;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output pi_data, pi_flag,
    input  pl_data, pl_flag, cmd_out, len_out, frame_ok, frame_err, err_code
  );

  modport slave (
    input  pi_data, pi_flag,
    output pl_data, pl_flag, cmd_out, len_out, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - decodes AA 55 CMD LEN PAYLOAD CHK frames, buffers and replays verified payloads
module uart_frame_parser #(
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 104_160
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int          AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_CMD, S_LEN, S_DATA, S_CHK, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_flag_q, pl_flag_d;
  logic [7:0]  cmd_out_q, cmd_out_d;
  logic [7:0]  len_out_q, len_out_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  buf_q [MAX_LEN];
  logic        buf_we;

  logic in_frame, timeout_hit, len_over, chk_ok, emit_more;

  // A strobe landing on the expiry cycle wins over the timeout.
  assign in_frame    = state_q inside {S_HDR2, S_CMD, S_LEN, S_DATA, S_CHK};
  assign timeout_hit = in_frame && !bus.pi_flag && ((cnt_q + 24'd1) == TO_LAST);
  assign len_over    = bus.pi_data > 8'(MAX_LEN);
  assign chk_ok      = bus.pi_data == sum_q;
  assign emit_more   = idx_q < len_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.pi_flag && bus.pi_data == 8'hAA) state_d = S_HDR2;
      S_HDR2: if (bus.pi_flag) begin
        if (bus.pi_data == 8'h55)      state_d = S_CMD;
        else if (bus.pi_data != 8'hAA) state_d = S_IDLE;
      end
      S_CMD:  if (bus.pi_flag) state_d = S_LEN;
      S_LEN:  if (bus.pi_flag) begin
        if (len_over)                 state_d = S_IDLE;
        else if (bus.pi_data == 8'd0) state_d = S_CHK;
        else                          state_d = S_DATA;
      end
      S_DATA: if (bus.pi_flag && idx_q == len_q - 8'd1) state_d = S_CHK;
      S_CHK:  if (bus.pi_flag) state_d = (chk_ok && len_q != 8'd0) ? S_OUT : S_IDLE;
      S_OUT:  if (!emit_more) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d       = (bus.pi_flag || !in_frame) ? 24'd0 : cnt_q + 24'd1;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    pl_data_d   = pl_data_q;
    pl_flag_d   = 1'b0;
    cmd_out_d   = cmd_out_q;
    len_out_d   = len_out_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    case (state_q)
      S_CMD: if (bus.pi_flag) begin
        cmd_d = bus.pi_data;
        sum_d = bus.pi_data;
      end
      S_LEN: if (bus.pi_flag) begin
        len_d = bus.pi_data;
        sum_d = sum_q + bus.pi_data;
        idx_d = 8'd0;
        if (len_over) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end
      end
      S_DATA: if (bus.pi_flag) begin
        buf_we = 1'b1;
        sum_d  = sum_q + bus.pi_data;
        idx_d  = idx_q + 8'd1;
      end
      S_CHK: if (bus.pi_flag) begin
        if (!chk_ok) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else if (len_q == 8'd0) begin
          frame_ok_d = 1'b1;
          cmd_out_d  = cmd_q;
          len_out_d  = len_q;
          err_code_d = 2'd0;
        end else begin
          // First replay byte leaves on the checksum edge so the burst starts at T+1.
          pl_flag_d = 1'b1;
          pl_data_d = buf_q[0];
          idx_d     = 8'd1;
        end
      end
      S_OUT: begin
        if (emit_more) begin
          pl_flag_d = 1'b1;
          pl_data_d = buf_q[idx_q[AW-1:0]];
          idx_d     = idx_q + 8'd1;
        end else begin
          frame_ok_d = 1'b1;
          cmd_out_d  = cmd_q;
          len_out_d  = len_q;
          err_code_d = 2'd0;
        end
      end
      default: ;
    endcase
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= 24'd0;
      idx_q       <= 8'd0;
      sum_q       <= 8'd0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      pl_data_q   <= 8'd0;
      pl_flag_q   <= 1'b0;
      cmd_out_q   <= 8'd0;
      len_out_q   <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      pl_data_q   <= pl_data_d;
      pl_flag_q   <= pl_flag_d;
      cmd_out_q   <= cmd_out_d;
      len_out_q   <= len_out_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload store needs no reset: only entries written by the current frame are replayed.
  always_ff @(posedge sys_clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= bus.pi_data;
  end

  assign bus.pl_data   = pl_data_q;
  assign bus.pl_flag   = pl_flag_q;
  assign bus.cmd_out   = cmd_out_q;
  assign bus.len_out   = len_out_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - self-checking bench for uart_frame_parser
module tb_uart_frame_parser;
  localparam int MAXL = 8;
  localparam int TOUT = 1000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   both_hi   = 0;

  uart_frame_parser_if bus();

  uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT(TOUT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0] pl_q[$];
  int         pl_t[$];
  int         ok_t[$];
  int         err_t[$];
  logic [7:0] pay[$];
  logic [7:0] raw[$];
  int         last_t;
  int         exp_cmd = 0;
  int         exp_len = 0;

  always @(negedge sys_clk) begin
    if (bus.pl_flag) begin
      pl_q.push_back(bus.pl_data);
      pl_t.push_back(cyc);
    end
    if (bus.frame_ok)  ok_t.push_back(cyc);
    if (bus.frame_err) err_t.push_back(cyc);
    if (bus.frame_ok && bus.frame_err) both_hi++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    pl_q.delete(); pl_t.delete(); ok_t.delete(); err_t.delete();
  endtask

  task automatic send_raw();
    foreach (raw[i]) begin
      bus.pi_data = raw[i];
      bus.pi_flag = 1'b1;
      last_t      = cyc;
      @(posedge sys_clk); #1;
    end
    bus.pi_flag = 1'b0;
  endtask

  // Expected outcome follows from how the frame was built, not from decoding it.
  task automatic do_frame(input int cmd, input int len, input bit corrupt, input string tag);
    int sum, code, t;
    bit good;
    if (pay.size() != len) begin
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    end
    sum = cmd + len;
    foreach (pay[i]) sum += pay[i];
    sum = sum % 256;
    code = (len > MAXL) ? 1 : (corrupt ? 2 : 0);
    good = (code == 0);
    raw = '{8'hAA, 8'h55, 8'(cmd), 8'(len)};
    if (len <= MAXL) begin
      foreach (pay[i]) raw.push_back(pay[i]);
      raw.push_back(corrupt ? 8'(sum ^ 1) : 8'(sum));
    end
    clear_mon();
    send_raw();
    t = last_t;
    repeat (len + 6) @(posedge sys_clk);
    #1;
    if (good) begin
      exp_cmd = cmd;
      exp_len = len;
      chk({tag, "_pl_count"}, pl_q.size(), len);
      for (int i = 0; i < pl_q.size() && i < len; i++) begin
        chk({tag, "_pl_data"}, pl_q[i], pay[i]);
        chk({tag, "_pl_cycle"}, pl_t[i], t + 1 + i);
      end
      chk({tag, "_ok_count"}, ok_t.size(), 1);
      if (ok_t.size() > 0) chk({tag, "_ok_cycle"}, ok_t[0], t + len + 1);
      chk({tag, "_err_count"}, err_t.size(), 0);
    end else begin
      chk({tag, "_pl_count"}, pl_q.size(), 0);
      chk({tag, "_ok_count"}, ok_t.size(), 0);
      chk({tag, "_err_count"}, err_t.size(), 1);
      if (err_t.size() > 0) chk({tag, "_err_cycle"}, err_t[0], t + 1);
    end
    chk({tag, "_err_code"}, bus.err_code, code);
    chk({tag, "_cmd_out"}, bus.cmd_out, exp_cmd);
    chk({tag, "_len_out"}, bus.len_out, exp_len);
    pay.delete();
  endtask

  initial begin
    int t;
    bus.pi_data = 8'd0;
    bus.pi_flag = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs", {bus.pl_data, bus.pl_flag, bus.cmd_out, bus.len_out,
                          bus.frame_ok, bus.frame_err, bus.err_code}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    pay = '{8'h11, 8'h22, 8'h33};
    do_frame(1, 3, 1'b0, "good");
    pay = '{8'h11, 8'h22, 8'h33};
    do_frame(1, 3, 1'b1, "badchk");
    do_frame(5, 9, 1'b0, "oversize");
    do_frame(7, 2, 1'b0, "after_over");
    do_frame(9, 8, 1'b0, "maxlen");

    raw = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h02, 8'h00, 8'h02};
    clear_mon();
    send_raw();
    t = last_t;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("resync_ok_count", ok_t.size(), 1);
    if (ok_t.size() > 0) chk("resync_ok_cycle", ok_t[0], t + 1);
    chk("resync_pl_count", pl_q.size(), 0);
    chk("resync_cmd", bus.cmd_out, 2);
    chk("resync_len", bus.len_out, 0);
    exp_cmd = 2;
    exp_len = 0;

    raw = '{8'hAA, 8'h55, 8'h01};
    clear_mon();
    send_raw();
    t = last_t;
    repeat (TOUT + 10) @(posedge sys_clk);
    #1;
    chk("timeout_err_count", err_t.size(), 1);
    if (err_t.size() > 0) chk("timeout_err_cycle", err_t[0], t + TOUT);
    chk("timeout_code", bus.err_code, 3);
    chk("timeout_ok_count", ok_t.size(), 0);

    raw = '{8'hAA, 8'h55, 8'h01};
    clear_mon();
    send_raw();
    t = last_t;
    while (cyc < t + TOUT - 1) begin
      @(posedge sys_clk); #1;
    end
    raw = '{8'h00, 8'h01};
    send_raw();
    repeat (TOUT + 10) @(posedge sys_clk);
    #1;
    chk("inject_err_count", err_t.size(), 0);
    chk("inject_ok_count", ok_t.size(), 1);
    chk("inject_code", bus.err_code, 0);
    chk("inject_cmd", bus.cmd_out, 1);
    exp_cmd = 1;
    exp_len = 0;

    for (int n = 0; n < 12; n++) begin
      do_frame($urandom_range(0, 255), $urandom_range(0, 10), $urandom_range(0, 3) == 0, "rand");
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      #1;
    end

    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom_range(0, 255)));
    t = 8'h3C + 8;
    foreach (pay[i]) t += pay[i];
    raw = '{8'hAA, 8'h55, 8'h3C, 8'h08};
    foreach (pay[i]) raw.push_back(pay[i]);
    raw.push_back(8'(t % 256));
    clear_mon();
    send_raw();
    t = last_t;
    while (cyc < t + 3) begin
      @(posedge sys_clk); #1;
    end
    sys_rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {bus.pl_data, bus.pl_flag, bus.cmd_out, bus.len_out,
                             bus.frame_ok, bus.frame_err, bus.err_code}, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    chk("midreset_ok_count", ok_t.size(), 0);
    chk("midreset_pl_count", pl_q.size(), 2);
    exp_cmd = 0;
    exp_len = 0;
    pay.delete();
    do_frame(8'h5A, 4, 1'b0, "post_reset");

    chk("ok_err_exclusive", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
